bcd_updown_counter_n: RTL and testbench
=======================================

# bcd_updown_counter_n

Parametrised N-digit BCD up/down counter with push-button edge detection, synchronous parallel load, wrap or saturate mode, and per-digit 7-segment drive. It replaces fixed three-stage cascaded digit counters on the board front panel. It feeds the LED bank and FND displays directly. Its carry and borrow pulses let several instances be chained.

## Interface
Parameters:
- DIGITS, 3, number of BCD digits (1..8)
- SATURATE, 0, 0 = wrap at max/min; 1 = hold at max/min
- FND_ACTIVE_LOW, 1, 1 = segment outputs active-low (common anode)

Ports:
- i_Clk  in  1  system clock; all state on rising edge
- i_Rst  in  1  reset, asynchronous assert, active-low
- i_Push  in  2  raw buttons, asynchronous; bit0 = up, bit1 = down
- i_Load  in  1  synchronous parallel load strobe (already in i_Clk domain)
- i_Data  in  4*DIGITS  load value, digit k at bits [4k+3:4k]
- o_LED  out  4*DIGITS  current count, BCD, digit 0 = least significant
- o_FND  out  7*DIGITS  segments for digit k at [7k+6:7k], order g..a (bit0 = a)
- o_Carry  out  1  one-cycle pulse on up-overflow
- o_Borrow  out  1  one-cycle pulse on down-underflow

## Operation
- Each i_Push bit passes a 2-flop synchroniser, then a rising-edge detector (previous-sample flop). This gives one pulse per 0→1 press, not per held level.
- Priority per cycle is i_Load, then (up XOR down) pulse, then hold. Up and down pulses in the same cycle: no change, no flags.
- Load:
  - count ← i_Data, digit by digit.
  - Any nibble > 9 is stored as 0.
  - A push pulse in the same cycle is discarded.
  - o_Carry and o_Borrow stay 0.
- Up, digit chain:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and propagates an increment to the next digit.
  - The whole chain resolves in one cycle.
- Down: mirror of Up. A digit at 0 becomes 9 and propagates a decrement.
- Overflow (up at all-9s):
  - SATURATE = 0: count → all-0.
  - SATURATE = 1: count holds all-9s.
  - o_Carry pulses for 1 cycle in both modes.
- Underflow (down at all-0s):
  - SATURATE = 0: count → all-9s.
  - SATURATE = 1: hold.
  - o_Borrow pulses for 1 cycle.
- o_FND is a combinational decode of registered o_LED.
  - Digits 0-9 use the standard pattern: 0 = a..f on (active-high 7'b0111111).
  - FND_ACTIVE_LOW inverts all segments.
  - Codes > 9 cannot occur.

## Timing
- Reset (i_Rst = 0):
  - Takes effect immediately.
  - Synchroniser and edge flops, count, o_Carry and o_Borrow all clear to 0.
  - o_FND shows "0" on every digit (7'b1000000 per digit when active-low).
- After i_Rst releases, a button already held high produces exactly one count, because the edge flops start at 0.
- Push latency: if i_Push[b] is first sampled high at edge E0, the pulse is valid between E1 and E2, and o_LED updates at E2.
- o_Carry and o_Borrow are registered. They assert on the same edge as the count change and deassert on the next edge.
- Load latency: i_Load high at edge E, so o_LED = i_Data after E.
- Minimum press spacing is 3 cycles (release plus re-press must each be sampled). Bouncing inputs count every clean edge; debouncing belongs upstream.
- Reset asserted mid-press discards any pulse in flight. No count change or flag follows the reset.

## Structure
- Shared package bcd_pkg holds:
  - BCD_MAX = 4'd9.
  - Seven-segment constants SEG_0..SEG_9, active-high, g..a order.
  - A function seg_decode(bcd) returning the 7-bit pattern.
- Sub-module bcd_digit_cell, one per digit, generated DIGITS times:
  - Inputs: inc, dec, load, load_val.
  - Outputs: 4-bit value, carry_out, borrow_out.
  - Carry and borrow chain combinationally from cell k to cell k+1.
- Top level holds:
  - The synchroniser and edge detect.
  - Priority logic.
  - Global all-9s / all-0s detection for saturate and flags.
  - The FND decode generate loop.

## Test plan
- Reset, then DIGITS = 3: o_LED = 12'h000, o_FND = 21'b1000000_1000000_1000000, o_Carry = 0.
- Pulse i_Push[0] 1 → 0 eleven times at 4-cycle spacing: o_LED = 12'h011, changing exactly 2 edges after each first-high sample. Hold i_Push[0] high for 20 cycles: only one increment.
- Load 12'h999, then one up press:
  - SATURATE = 0: o_LED = 12'h000, o_Carry high for exactly 1 cycle.
  - SATURATE = 1: o_LED stays 12'h999, o_Carry still pulses.
- From 12'h000, one down press (SATURATE = 0): o_LED = 12'h999, o_Borrow pulses once. Up and down pressed on the same edge: no change, no flags.
- Load 12'hA5F with an up pulse landing in the same cycle: o_LED = 12'h050 and the push is ignored.
- Assert i_Rst low for a fraction of a cycle, 1 cycle after a press edge: count returns to 0 asynchronously, and no increment or flag follows the release.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared BCD counter definitions: digit/segment widths, BCD limits,
// seven-segment patterns (active-high, g..a order, bit0 = a) and helpers.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  localparam logic [SEG_W-1:0] SEG_0 = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b1011011;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b1100110;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b1101101;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b1111101;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b0000111;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b1101111;

  // Synchronised push-button edge pulses, bit0 = up, bit1 = down.
  typedef struct packed {
    logic down;
    logic up;
  } push_t;

  // Active-high segment pattern for one BCD digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [DIGIT_W-1:0] bcd);
    logic [SEG_W-1:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_0;  // stored digits never exceed 9
    endcase
    return seg;
  endfunction

  // Non-BCD load nibbles are stored as zero.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nib);
    return (nib > BCD_MAX) ? BCD_ZERO : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit register with load, increment and decrement.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   inc, dec    step requests (mutually exclusive), from the digit below
//   load        parallel load, overrides inc/dec
//   load_val    load nibble, values above 9 are stored as 0
//   value       registered digit
//   carry_out   combinational increment request for the next digit
//   borrow_out  combinational decrement request for the next digit
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  input  logic               dec,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] value,
  output logic               carry_out,
  output logic               borrow_out
);

  logic [DIGIT_W-1:0] value_nxt;

  // Next digit value and ripple requests.
  always_comb begin
    value_nxt  = value;
    carry_out  = 1'b0;
    borrow_out = 1'b0;
    if (load) begin
      value_nxt = bcd_clamp(load_val);
    end else if (inc) begin
      if (value == BCD_MAX) begin
        value_nxt = BCD_ZERO;
        carry_out = 1'b1;
      end else begin
        value_nxt = value + DIGIT_W'(1);
      end
    end else if (dec) begin
      if (value == BCD_ZERO) begin
        value_nxt  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        value_nxt = value - DIGIT_W'(1);
      end
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= BCD_ZERO;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter driven by push buttons, with parallel load,
// wrap or saturate at the limits, chainable carry/borrow pulses and
// per-digit seven-segment outputs.
// Ports:
//   i_Clk     system clock
//   i_Rst     async active-low reset
//   i_Push    raw buttons, bit0 = up, bit1 = down (asynchronous)
//   i_Load    synchronous parallel load strobe
//   i_Data    load value, digit k at [4k+3:4k]
//   o_LED     registered BCD count, digit 0 least significant
//   o_FND     segment drive for digit k at [7k+6:7k], g..a order
//   o_Carry   one-cycle pulse on up-overflow
//   o_Borrow  one-cycle pulse on down-underflow
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS         = 3,
  parameter bit          SATURATE       = 1'b0,
  parameter bit          FND_ACTIVE_LOW = 1'b1
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst,
  input  logic [1:0]                i_Push,
  input  logic                      i_Load,
  input  logic [DIGIT_W*DIGITS-1:0] i_Data,
  output logic [DIGIT_W*DIGITS-1:0] o_LED,
  output logic [SEG_W*DIGITS-1:0]   o_FND,
  output logic                      o_Carry,
  output logic                      o_Borrow
);

  logic [1:0]        push_meta;
  logic [1:0]        push_sync;
  logic [1:0]        push_prev;
  push_t             pulse;
  logic              up_req;
  logic              dn_req;
  logic              all_nine;
  logic              all_zero;
  logic              inc0;
  logic              dec0;
  logic              carry_nxt;
  logic              borrow_nxt;
  logic [DIGITS-1:0] is_nine;
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] inc_in;
  logic [DIGITS-1:0] dec_in;
  logic [DIGITS-1:0] carry_c;
  logic [DIGITS-1:0] borrow_c;

  // Two-flop synchroniser plus previous-sample flop for edge detection.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      push_meta <= 2'b00;
      push_sync <= 2'b00;
      push_prev <= 2'b00;
    end else begin
      push_meta <= i_Push;
      push_sync <= push_meta;
      push_prev <= push_sync;
    end
  end

  // Load wins over pushes; simultaneous up and down cancel.
  always_comb begin
    pulse      = push_t'(push_sync & ~push_prev);
    up_req     = pulse.up & ~pulse.down & ~i_Load;
    dn_req     = pulse.down & ~pulse.up & ~i_Load;
    all_nine   = &is_nine;
    all_zero   = &is_zero;
    // In saturate mode the chain is never started at the limit, so the
    // flag comes from the limit detect instead of the last cell's ripple.
    inc0       = up_req & ~(SATURATE & all_nine);
    dec0       = dn_req & ~(SATURATE & all_zero);
    carry_nxt  = carry_c[DIGITS-1]  | (SATURATE & up_req & all_nine);
    borrow_nxt = borrow_c[DIGITS-1] | (SATURATE & dn_req & all_zero);
  end

  // Digit chain: cell k steps when every lower digit rolls over.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    if (k == 0) begin : g_first
      assign inc_in[k] = inc0;
      assign dec_in[k] = dec0;
    end else begin : g_rest
      assign inc_in[k] = carry_c[k-1];
      assign dec_in[k] = borrow_c[k-1];
    end

    bcd_digit_cell u_cell (
      .clk        (i_Clk),
      .rst_n      (i_Rst),
      .inc        (inc_in[k]),
      .dec        (dec_in[k]),
      .load       (i_Load),
      .load_val   (i_Data[DIGIT_W*k +: DIGIT_W]),
      .value      (o_LED[DIGIT_W*k +: DIGIT_W]),
      .carry_out  (carry_c[k]),
      .borrow_out (borrow_c[k])
    );

    assign is_nine[k] = (o_LED[DIGIT_W*k +: DIGIT_W] == BCD_MAX);
    assign is_zero[k] = (o_LED[DIGIT_W*k +: DIGIT_W] == BCD_ZERO);

    // Segment decode of the registered digit.
    assign o_FND[SEG_W*k +: SEG_W] = FND_ACTIVE_LOW
                                   ? ~seg_decode(o_LED[DIGIT_W*k +: DIGIT_W])
                                   :  seg_decode(o_LED[DIGIT_W*k +: DIGIT_W]);
  end

  // Overflow / underflow flags, one cycle wide.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Carry  <= 1'b0;
      o_Borrow <= 1'b0;
    end else begin
      o_Carry  <= carry_nxt;
      o_Borrow <= borrow_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: a wrap instance and a saturate instance
// share stimulus; a decimal-integer model tracks each count.
module tb_bcd_updown_counter_n;

  localparam int DIG  = 3;
  localparam int MAXV = 999;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  push  = 2'b00;
  logic        load  = 1'b0;
  logic [11:0] data  = 12'h000;
  logic [11:0] led0, led1;
  logic [20:0] fnd0, fnd1;
  logic        c0, c1, b0, b1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.DIGITS(DIG), .SATURATE(1'b0), .FND_ACTIVE_LOW(1'b1)) dut0 (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .i_Load(load), .i_Data(data),
    .o_LED(led0), .o_FND(fnd0), .o_Carry(c0), .o_Borrow(b0));

  bcd_updown_counter_n #(.DIGITS(DIG), .SATURATE(1'b1), .FND_ACTIVE_LOW(1'b1)) dut1 (
    .i_Clk(clk), .i_Rst(rst_n), .i_Push(push), .i_Load(load), .i_Data(data),
    .o_LED(led1), .o_FND(fnd1), .o_Carry(c1), .o_Borrow(b1));

  // ---------------- reference model ----------------
  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = v;
    for (int k = 0; k < DIG; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int load_value(input logic [11:0] d);
    int v;
    logic [3:0] nib;
    v = 0;
    for (int k = DIG - 1; k >= 0; k--) begin
      nib = d[4*k +: 4];
      v = v * 10 + ((nib > 4'd9) ? 0 : int'(nib));
    end
    return v;
  endfunction

  function automatic logic [20:0] fnd_of(input int v);
    logic [20:0] r;
    logic [6:0]  s;
    int x;
    x = v;
    for (int k = 0; k < DIG; k++) begin
      case (x % 10)
        0: s = 7'h3F; 1: s = 7'h06; 2: s = 7'h5B; 3: s = 7'h4F; 4: s = 7'h66;
        5: s = 7'h6D; 6: s = 7'h7D; 7: s = 7'h07; 8: s = 7'h7F; default: s = 7'h6F;
      endcase
      r[7*k +: 7] = ~s;
      x = x / 10;
    end
    return r;
  endfunction

  // p: button press pulses acting at this edge (bit0 up, bit1 down).
  function automatic int next_cnt(input int c, input bit sat, input logic [1:0] p,
                                  input logic ld, input logic [11:0] d);
    if (ld) return load_value(d);
    if (p == 2'b01) return (c == MAXV) ? (sat ? MAXV : 0) : c + 1;
    if (p == 2'b10) return (c == 0) ? (sat ? 0 : MAXV) : c - 1;
    return c;
  endfunction

  // Raw button samples taken 1, 2 and 3 edges ago; a press sampled first at
  // edge E0 acts on the count at E0+2.
  logic [1:0] h1 = 2'b00, h2 = 2'b00, h3 = 2'b00;
  int         m_cnt [2] = '{0, 0};
  bit         m_car [2] = '{1'b0, 1'b0};
  bit         m_bor [2] = '{1'b0, 1'b0};
  wire  [1:0] m_p = h2 & ~h3;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1 <= 2'b00; h2 <= 2'b00; h3 <= 2'b00;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] <= 0; m_car[s] <= 1'b0; m_bor[s] <= 1'b0;
      end
    end else begin
      h1 <= push; h2 <= h1; h3 <= h2;
      for (int s = 0; s < 2; s++) begin
        m_cnt[s] <= next_cnt(m_cnt[s], s == 1, m_p, load, data);
        m_car[s] <= !load && m_p == 2'b01 && m_cnt[s] == MAXV;
        m_bor[s] <= !load && m_p == 2'b10 && m_cnt[s] == 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [11:0] d);
    load = 1'b1; data = d;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Press for one sampled cycle, return just after the count edge (E0+2).
  task automatic press(input logic [1:0] b);
    push = b;
    @(negedge clk);
    push = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    push = 2'b00; load = 1'b0; data = 12'h000;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (led0 !== 12'h000) begin bad++; $display("FAIL reset_led got=%h want=000", led0); end
    total++; if (led1 !== 12'h000) begin bad++; $display("FAIL reset_led_sat got=%h want=000", led1); end
    total++; if (fnd0 !== 21'b1000000_1000000_1000000) begin bad++; $display("FAIL reset_fnd got=%b", fnd0); end
    total++; if (c0 !== 1'b0 || b0 !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", c0, b0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_up_latency;
    logic [11:0] exp;
    for (int i = 0; i < 11; i++) begin
      push = 2'b01;
      @(negedge clk);                       // after E0
      push = 2'b00;
      exp = to_bcd(i);
      total++; if (led0 !== exp) begin bad++; $display("FAIL up_early_e0 i=%0d got=%h want=%h", i, led0, exp); end
      @(negedge clk);                       // after E1
      total++; if (led0 !== exp) begin bad++; $display("FAIL up_early_e1 i=%0d got=%h want=%h", i, led0, exp); end
      @(negedge clk);                       // after E2
      exp = to_bcd(i + 1);
      total++; if (led0 !== exp || led1 !== exp) begin bad++; $display("FAIL up_step i=%0d got=%h/%h want=%h", i, led0, led1, exp); end
      @(negedge clk);
    end
    total++; if (led0 !== 12'h011) begin bad++; $display("FAIL up_eleven got=%h want=011", led0); end
    total++; if (fnd0 !== fnd_of(11)) begin bad++; $display("FAIL up_fnd got=%b want=%b", fnd0, fnd_of(11)); end
  endtask

  task automatic test_hold;
    push = 2'b01;
    repeat (20) @(negedge clk);
    push = 2'b00;
    repeat (4) @(negedge clk);
    total++; if (led0 !== 12'h012) begin bad++; $display("FAIL hold_once got=%h want=012", led0); end
  endtask

  task automatic test_overflow;
    do_load(12'h999);
    total++; if (led0 !== 12'h999 || led1 !== 12'h999) begin bad++; $display("FAIL ovf_load got=%h/%h want=999", led0, led1); end
    press(2'b01);
    total++; if (led0 !== 12'h000) begin bad++; $display("FAIL ovf_wrap got=%h want=000", led0); end
    total++; if (led1 !== 12'h999) begin bad++; $display("FAIL ovf_sat got=%h want=999", led1); end
    total++; if (c0 !== 1'b1 || c1 !== 1'b1) begin bad++; $display("FAIL ovf_carry got=%b%b want=11", c0, c1); end
    @(negedge clk);
    total++; if (c0 !== 1'b0 || c1 !== 1'b0) begin bad++; $display("FAIL ovf_carry_len got=%b%b want=00", c0, c1); end
  endtask

  task automatic test_underflow;
    do_load(12'h000);
    press(2'b10);
    total++; if (led0 !== 12'h999) begin bad++; $display("FAIL unf_wrap got=%h want=999", led0); end
    total++; if (led1 !== 12'h000) begin bad++; $display("FAIL unf_sat got=%h want=000", led1); end
    total++; if (b0 !== 1'b1 || b1 !== 1'b1) begin bad++; $display("FAIL unf_borrow got=%b%b want=11", b0, b1); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL unf_no_carry got=%b want=0", c0); end
    @(negedge clk);
    total++; if (b0 !== 1'b0 || b1 !== 1'b0) begin bad++; $display("FAIL unf_borrow_len got=%b%b want=00", b0, b1); end
  endtask

  task automatic test_both;
    push = 2'b11;
    @(negedge clk);
    push = 2'b00;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (led0 !== 12'h999 || led1 !== 12'h000 || c0 || b0 || c1 || b1) begin
        bad++; $display("FAIL both_pressed cyc=%0d got=%h/%h flags=%b%b%b%b", i, led0, led1, c0, b0, c1, b1);
      end
    end
  endtask

  task automatic test_load_push;
    push = 2'b01;
    @(negedge clk);                         // after E0
    push = 2'b00;
    @(negedge clk);                         // after E1, pulse now live
    load = 1'b1; data = 12'hA5F;
    @(negedge clk);                         // after E2
    load = 1'b0;
    total++; if (led0 !== 12'h050 || led1 !== 12'h050) begin bad++; $display("FAIL load_clamp got=%h/%h want=050", led0, led1); end
    total++; if (c0 !== 1'b0 || b0 !== 1'b0) begin bad++; $display("FAIL load_flags got=%b%b want=00", c0, b0); end
    repeat (3) @(negedge clk);
    total++; if (led0 !== 12'h050) begin bad++; $display("FAIL load_push_ignored got=%h want=050", led0); end
  endtask

  task automatic test_reset_mid_press;
    do_load(12'h123);
    push = 2'b01;
    @(negedge clk);                         // after E0
    push = 2'b00;
    @(posedge clk);                         // E1
    #1 rst_n = 1'b0;
    #1;
    total++; if (led0 !== 12'h000 || led1 !== 12'h000) begin bad++; $display("FAIL rst_async got=%h/%h want=000", led0, led1); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (led0 !== 12'h000 || c0 !== 1'b0 || b0 !== 1'b0) begin
        bad++; $display("FAIL rst_no_pulse cyc=%0d got=%h flags=%b%b", i, led0, c0, b0);
      end
    end
  endtask

  task automatic test_random;
    logic [11:0] e0, e1;
    for (int i = 0; i < 600; i++) begin
      e0 = to_bcd(m_cnt[0]);
      e1 = to_bcd(m_cnt[1]);
      total++; if (led0 !== e0 || led1 !== e1) begin bad++; $display("FAIL rand_led cyc=%0d got=%h/%h want=%h/%h", i, led0, led1, e0, e1); end
      total++; if (fnd0 !== fnd_of(m_cnt[0]) || fnd1 !== fnd_of(m_cnt[1])) begin bad++; $display("FAIL rand_fnd cyc=%0d got=%b want=%b", i, fnd0, fnd_of(m_cnt[0])); end
      total++; if (c0 !== m_car[0] || c1 !== m_car[1] || b0 !== m_bor[0] || b1 !== m_bor[1]) begin
        bad++; $display("FAIL rand_flags cyc=%0d got=%b%b%b%b want=%b%b%b%b", i, c0, c1, b0, b1, m_car[0], m_car[1], m_bor[0], m_bor[1]);
      end
      push = 2'($urandom_range(0, 3));
      load = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 5))
        0: data = 12'h999;
        1: data = 12'h000;
        2: data = 12'h998;
        3: data = 12'h001;
        default: data = 12'($urandom);
      endcase
      @(negedge clk);
    end
    push = 2'b00; load = 1'b0;
  endtask

  initial begin
    test_reset;
    test_up_latency;
    test_hold;
    test_overflow;
    test_underflow;
    test_both;
    test_load_push;
    test_reset_mid_press;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
